fp_sqrt_iter: RTL and testbench
===============================

// Module: fp_sqrt_iter
// PURPOSE
//  Parametrised IEEE-754 square-root unit for the FP datapath; successor of the multi-clock sqrt.
//  Single clock, valid/ready handshake on input and output, restoring digit recurrence (one root bit per cycle).
//  Handles IEEE special cases, round-to-nearest-even (RNE) rounding and exception flags.
//  Sits behind the FP issue logic, which presents one operand and waits for one result.
// PARAMETERS
//  EXP_W  8   exponent field width (5 = half, 8 = single, 11 = double)
//  MAN_W  23  stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1   sole clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operand present on in_a
//  in_ready   out  1   unit idle, operand accepted when in_valid&in_ready
//  in_a       in   W   IEEE operand {sign,exp,frac}
//  out_valid  out  1   result/flags valid, held until accepted
//  out_ready  in   1   consumer takes result when out_valid&out_ready
//  out_q      out  W   IEEE result
//  out_flags  out  3   {invalid, inexact, denorm_flushed}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_q=0, out_flags=0, counter=0.
//  FSM IDLE -> UNPACK -> CALC -> ROUND -> DONE -> IDLE.
//  IDLE:   in_ready=1; accept on in_valid -> latch in_a, go UNPACK. No other state accepts input.
//  UNPACK (1 cycle): classify. e=E-BIAS, BIAS=2^(EXP_W-1)-1.
//    If e is odd: radicand={1,frac}<<1 and e-=1; else radicand={1,frac}.
//    Radicand is left-aligned in a 2*(MAN_W+2)-bit register; root exponent = e/2+BIAS (arithmetic shift).
//  CALC (exactly MAN_W+2 cycles): restoring step per cycle; trial=(rem<<2|next 2 radicand bits) - (root<<2|1).
//    Non-negative trial -> root bit 1 and rem=trial; else root bit 0. Counter counts down to 0, then ROUND.
//  ROUND (1 cycle): root = 1.frac(MAN_W) + guard; sticky = rem!=0. RNE: increment if guard&(sticky|lsb).
//    Mantissa carry-out -> exponent+1, fraction 0. inexact = guard|sticky.
//  DONE: out_valid=1; out_q/out_flags stable while out_ready=0. Handshake -> IDLE, out_valid=0 next cycle.
//  Fixed latency for every input, specials included: accept edge to out_valid high = MAN_W+4 cycles (27 single).
//  Specials are decided in UNPACK and pass through CALC/ROUND with the result forced:
//    +-0 -> same signed zero, flags 0.
//    Denormal (E=0, frac!=0) -> signed zero, denorm_flushed=1.
//    +inf -> +inf.
//    -inf, negative nonzero finite, NaN -> canonical qNaN {0,all-1s,1,0...}, invalid=1.
//    A NaN input always sets invalid (sNaN/qNaN are not distinguished).
//  Throughput: one operation in flight; next accept no earlier than the cycle after the output handshake.
//  in_valid while busy: ignored (in_ready=0); the operand must be held by the producer.
//  rst_n low mid-operation: abort immediately, return to reset values; no result ever appears.
//  out_ready high before out_valid: no effect.
// STRUCTURE
//  fp_pkg: BIAS function of EXP_W, field-extract widths, canonical-NaN constant, FSM state enum, flag bit indices.
//  Sub-module sqrt_iter_core: restoring integer sqrt datapath (rem/root/radicand regs + step counter).
//    Controlled by start/done from the top FSM; parameter ROOT_W=MAN_W+2.
//  Top level keeps unpack/classify, FSM, rounding, packing and handshake.
// TESTING
//  Single 3f800000 (1.0) -> 3f800000, flags 000, out_valid exactly 27 cycles after accept.
//  40800000 (4.0) -> 40000000; 461c4000 (10000) -> 42c80000; all exact, inexact=0.
//  40000000 (2.0) -> 3fb504f3, inexact=1 (RNE check).
//  Specials: 00000000 -> 00000000; 80000000 -> 80000000; 7f800000 -> 7f800000;
//    bf800000 -> 7fc00000 invalid=1; 00000001 -> 00000000 denorm_flushed=1.
//  Handshake: hold out_ready=0 for 10 cycles -> out_q/out_flags/out_valid stable, in_ready=0 throughout;
//    a second in_valid pulse while busy is not accepted.
//  Reset: drop rst_n in cycle 10 of CALC -> all outputs at reset values, in_ready=1 after release, no out_valid.
//  Half config (EXP_W=5, MAN_W=10): 4400 -> 4000, 3c00 -> 3c00, latency 14.

Source files
------------

// File: rtl/fp_sqrt_iter_pkg.sv
// Shared definitions for the iterative IEEE-754 square-root unit:
// controller states, flag bit positions and format helper functions.
package fp_sqrt_iter_pkg;

   // Flag vector layout: {invalid, inexact, denorm_flushed}
   localparam int FLAGS_W      = 3;
   localparam int FLAG_INVALID = 2;
   localparam int FLAG_INEXACT = 1;
   localparam int FLAG_DENORM  = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_CALC   = 3'd2,
      ST_ROUND  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Exponent bias for a given exponent field width.
   function automatic int bias_of(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical quiet NaN {0, all-ones exponent, 1, 0...}, right-aligned in 64 bits.
   function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < exp_w; i++) begin
         w[man_w + i] = 1'b1;
      end
      w[man_w - 1] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/fp_sqrt_iter_core.sv
// Restoring integer square-root datapath: one root bit per cycle.
// Loaded by start; steps while busy; done marks the cycle of the final step,
// after which root/rem hold the finished result until the next start.
module fp_sqrt_iter_core #(
   parameter int ROOT_W = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2*ROOT_W-1:0]   radicand,
   output logic                  done,
   output logic [ROOT_W-2:0]     root_low,
   output logic [ROOT_W+1:0]     rem
);

   localparam int RAD_W = 2 * ROOT_W;
   localparam int REM_W = ROOT_W + 2;
   localparam int CNT_W = $clog2(ROOT_W);

   logic [RAD_W-1:0]  rad_q,  rad_d;
   logic [REM_W-1:0]  rem_q,  rem_d;
   logic [ROOT_W-1:0] root_q, root_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic              busy_q, busy_d;

   logic [REM_W+1:0]  shifted;
   logic              take;

   // One restoring step: bring down two radicand bits, compare with (root<<2|1).
   always_comb begin
      rad_d   = rad_q;
      rem_d   = rem_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      shifted = {rem_q, rad_q[RAD_W-1 -: 2]};
      take    = (shifted >= {2'b00, root_q, 2'b01});
      if (start) begin
         rad_d  = radicand;
         rem_d  = '0;
         root_d = '0;
         cnt_d  = CNT_W'(ROOT_W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rad_d  = rad_q << 2;
         rem_d  = take ? REM_W'(shifted - {2'b00, root_q, 2'b01}) : REM_W'(shifted);
         root_d = {root_q[ROOT_W-2:0], take};
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rad_q  <= rad_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // The leading root bit is always 1 for a normalised radicand, so only the rest leaves.
   always_comb begin
      done     = busy_q && (cnt_q == '0);
      root_low = root_q[ROOT_W-2:0];
      rem      = rem_q;
   end

endmodule

// File: rtl/fp_sqrt_iter.sv
// IEEE-754 square root with valid/ready handshakes and RNE rounding.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready is high only when idle, out_valid holds the result until out_ready.
module fp_sqrt_iter
   import fp_sqrt_iter_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_q,
   output logic [FLAGS_W-1:0]   out_flags
);

   localparam int W      = 1 + EXP_W + MAN_W;
   localparam int ROOT_W = MAN_W + 2;
   localparam int RAD_W  = 2 * ROOT_W;
   localparam int XE_W   = EXP_W + 2;
   localparam logic signed [XE_W-1:0] BIAS_X   = XE_W'(bias_of(EXP_W));
   localparam logic signed [XE_W-1:0] ONE_X    = XE_W'(1);
   localparam logic [EXP_W-1:0]       EXP_ONES = '1;
   localparam logic [W-1:0]           QNAN     = W'(qnan_word(EXP_W, MAN_W));

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic               special_q, special_d;
   logic [W-1:0]       spec_res_q, spec_res_d;
   logic [FLAGS_W-1:0] spec_flags_q, spec_flags_d;
   logic [EXP_W-1:0]   root_exp_q, root_exp_d;
   logic [W-1:0]       out_q_q, out_q_d;
   logic [FLAGS_W-1:0] out_flags_q, out_flags_d;

   logic               core_start, core_done;
   logic [ROOT_W-2:0]  core_root;
   logic [ROOT_W+1:0]  core_rem;

   logic                   a_sign;
   logic [EXP_W-1:0]       a_exp;
   logic [MAN_W-1:0]       a_frac;
   logic                   is_zero, is_denorm, is_inf, is_nan;
   logic signed [XE_W-1:0] e_unb, e_even;
   logic [RAD_W-1:0]       radicand;
   logic                   spec_hit;
   logic [W-1:0]           spec_val;
   logic [FLAGS_W-1:0]     spec_flg;

   logic                   guard, sticky, rnd_inc, rnd_carry;
   logic [MAN_W-1:0]       rnd_frac;
   logic [EXP_W-1:0]       rnd_exp;
   logic [W-1:0]           rnd_res;
   logic [FLAGS_W-1:0]     rnd_flags;

   fp_sqrt_iter_core #(.ROOT_W(ROOT_W)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (core_start),
      .radicand (radicand),
      .done     (core_done),
      .root_low (core_root),
      .rem      (core_rem)
   );

   // Unpack and classify the latched operand; odd exponents move one bit into the radicand.
   always_comb begin
      a_sign    = a_q[W-1];
      a_exp     = a_q[W-2 -: EXP_W];
      a_frac    = a_q[MAN_W-1:0];
      is_zero   = (a_exp == '0) && (a_frac == '0);
      is_denorm = (a_exp == '0) && (a_frac != '0);
      is_inf    = (a_exp == EXP_ONES) && (a_frac == '0);
      is_nan    = (a_exp == EXP_ONES) && (a_frac != '0);
      e_unb     = $signed({2'b00, a_exp}) - BIAS_X;
      e_even    = e_unb[0] ? (e_unb - ONE_X) : e_unb;
      radicand  = e_unb[0] ? {1'b1, a_frac, 1'b0, {ROOT_W{1'b0}}}
                           : {2'b01, a_frac, {ROOT_W{1'b0}}};
      spec_hit  = 1'b1;
      spec_val  = '0;
      spec_flg  = '0;
      if (is_nan) begin
         spec_val               = QNAN;
         spec_flg[FLAG_INVALID] = 1'b1;
      end else if (is_zero) begin
         spec_val = {a_sign, {(W-1){1'b0}}};
      end else if (is_denorm) begin
         spec_val              = {a_sign, {(W-1){1'b0}}};
         spec_flg[FLAG_DENORM] = 1'b1;
      end else if (a_sign) begin
         spec_val               = QNAN;
         spec_flg[FLAG_INVALID] = 1'b1;
      end else if (is_inf) begin
         spec_val = a_q;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Round the finished root to nearest-even; a mantissa carry bumps the exponent.
   always_comb begin
      guard                  = core_root[0];
      sticky                 = |core_rem;
      rnd_inc                = guard & (sticky | core_root[1]);
      {rnd_carry, rnd_frac}  = {1'b0, core_root[MAN_W:1]} + {{MAN_W{1'b0}}, rnd_inc};
      rnd_exp                = root_exp_q + {{(EXP_W-1){1'b0}}, rnd_carry};
      rnd_res                = {1'b0, rnd_exp, rnd_frac};
      rnd_flags              = '0;
      rnd_flags[FLAG_INEXACT] = guard | sticky;
   end

   // Operand capture, special-case decision and result registration.
   always_comb begin
      a_d          = a_q;
      special_d    = special_q;
      spec_res_d   = spec_res_q;
      spec_flags_d = spec_flags_q;
      root_exp_d   = root_exp_q;
      out_q_d      = out_q_q;
      out_flags_d  = out_flags_q;
      if ((state_q == ST_IDLE) && in_valid) begin
         a_d = in_a;
      end
      if (state_q == ST_UNPACK) begin
         special_d    = spec_hit;
         spec_res_d   = spec_val;
         spec_flags_d = spec_flg;
         root_exp_d   = EXP_W'((e_even >>> 1) + BIAS_X);
      end
      if (state_q == ST_ROUND) begin
         out_q_d     = special_q ? spec_res_q   : rnd_res;
         out_flags_d = special_q ? spec_flags_q : rnd_flags;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         special_q    <= 1'b0;
         spec_res_q   <= '0;
         spec_flags_q <= '0;
         root_exp_q   <= '0;
         out_q_q      <= '0;
         out_flags_q  <= '0;
      end else begin
         a_q          <= a_d;
         special_q    <= special_d;
         spec_res_q   <= spec_res_d;
         spec_flags_q <= spec_flags_d;
         root_exp_q   <= root_exp_d;
         out_q_q      <= out_q_d;
         out_flags_q  <= out_flags_d;
      end
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Controller next state: specials also run through CALC so latency never varies.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid)  state_d = ST_UNPACK;
         ST_UNPACK:                state_d = ST_CALC;
         ST_CALC:   if (core_done) state_d = ST_ROUND;
         ST_ROUND:                 state_d = ST_DONE;
         ST_DONE:   if (out_ready) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Controller outputs.
   always_comb begin
      in_ready   = (state_q == ST_IDLE);
      out_valid  = (state_q == ST_DONE);
      core_start = (state_q == ST_UNPACK);
      out_q      = out_q_q;
      out_flags  = out_flags_q;
   end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Bench for fp_sqrt_iter: single-precision and half-precision instances,
// constant vector table, random operands against an arithmetic reference,
// plus hand-written handshake and mid-operation reset sequences.
module tb_fp_sqrt_iter;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT: single precision ----------------
   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [31:0] s_in_a, s_out_q;
   logic [2:0]  s_out_flags;

   fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) u_dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_a      (s_in_a),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_q     (s_out_q),
      .out_flags (s_out_flags)
   );

   // ---------------- DUT: half precision ----------------
   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_in_a, h_out_q;
   logic [2:0]  h_out_flags;

   fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) u_dut_h (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (h_in_valid),
      .in_ready  (h_in_ready),
      .in_a      (h_in_a),
      .out_valid (h_out_valid),
      .out_ready (h_out_ready),
      .out_q     (h_out_q),
      .out_flags (h_out_flags)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];   // {flags at [34:32], word at [31:0]}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] isqrt(input logic [63:0] n);
      logic [63:0] lo, hi, mid;
      lo = 64'd0;
      hi = 64'd1 << 27;
      while (lo < hi) begin
         mid = (lo + hi + 64'd1) >> 1;
         if (mid * mid <= n) lo = mid;
         else hi = mid - 64'd1;
      end
      return lo;
   endfunction

   // Square root of the value encoded in a, rounded to nearest; returns {flags, word}.
   function automatic logic [63:0] ref_sqrt(input int exp_w, input int man_w, input logic [63:0] a);
      int          bias, e_all1, ex, e, eh, shift;
      logic        sgn;
      logic [63:0] frac, m, n, r, q, qnan, zero_s;
      logic [2:0]  f;
      bias   = (1 << (exp_w - 1)) - 1;
      e_all1 = (1 << exp_w) - 1;
      sgn    = a[exp_w + man_w];
      ex     = int'((a >> man_w) & 64'(e_all1));
      frac   = a & ((64'd1 << man_w) - 64'd1);
      qnan   = (64'(e_all1) << man_w) | (64'd1 << (man_w - 1));
      zero_s = 64'(sgn) << (exp_w + man_w);
      f      = 3'b000;
      q      = 64'd0;
      if (ex == e_all1 && frac != 0) begin
         q = qnan; f = 3'b100;
      end else if (ex == 0 && frac == 0) begin
         q = zero_s;
      end else if (ex == 0) begin
         q = zero_s; f = 3'b001;
      end else if (sgn) begin
         q = qnan; f = 3'b100;
      end else if (ex == e_all1) begin
         q = a;
      end else begin
         e = ex - bias;
         if (e % 2 != 0) begin
            shift = man_w + 1; eh = (e - 1) / 2;
         end else begin
            shift = man_w;     eh = e / 2;
         end
         m = (64'd1 << man_w) | frac;
         n = m << shift;
         r = isqrt(n);
         if ((64'd2 * r + 64'd1) * (64'd2 * r + 64'd1) < 64'd4 * n) r = r + 64'd1;
         if (r * r != n) f[1] = 1'b1;
         if (r == (64'd1 << (man_w + 1))) begin
            r  = r >> 1;
            eh = eh + 1;
         end
         q = (64'(eh + bias) << man_w) | (r & ((64'd1 << man_w) - 64'd1));
      end
      return {29'd0, f, q[31:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic run_s(input logic [31:0] a, output logic [31:0] q, output logic [2:0] f,
                        output int lat);
      int wait_c;
      @(negedge clk);
      s_in_a     = a;
      s_in_valid = 1'b1;
      wait_c     = 0;
      while (!s_in_ready && wait_c < 100) begin
         @(negedge clk);
         wait_c++;
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      q           = s_out_q;
      f           = s_out_flags;
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
   endtask

   task automatic run_h(input logic [15:0] a, output logic [15:0] q, output logic [2:0] f,
                        output int lat);
      int wait_c;
      @(negedge clk);
      h_in_a     = a;
      h_in_valid = 1'b1;
      wait_c     = 0;
      while (!h_in_ready && wait_c < 100) begin
         @(negedge clk);
         wait_c++;
      end
      @(negedge clk);
      h_in_valid = 1'b0;
      lat = 0;
      while (!h_out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      q           = h_out_q;
      f           = h_out_flags;
      h_out_ready = 1'b1;
      @(negedge clk);
      h_out_ready = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] q;
      logic [2:0]  f;
   } vec_t;

   vec_t vecs[12];

   // ---------------- watchdog ----------------
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] q32, a32;
      logic [15:0] q16, a16;
      logic [2:0]  fl;
      logic [63:0] e;
      int          lat;
      int          seen;

      vecs[0]  = '{32'h3f800000, 32'h3f800000, 3'b000};
      vecs[1]  = '{32'h40800000, 32'h40000000, 3'b000};
      vecs[2]  = '{32'h461c4000, 32'h42c80000, 3'b000};
      vecs[3]  = '{32'h40000000, 32'h3fb504f3, 3'b010};
      vecs[4]  = '{32'h00000000, 32'h00000000, 3'b000};
      vecs[5]  = '{32'h80000000, 32'h80000000, 3'b000};
      vecs[6]  = '{32'h7f800000, 32'h7f800000, 3'b000};
      vecs[7]  = '{32'hbf800000, 32'h7fc00000, 3'b100};
      vecs[8]  = '{32'h00000001, 32'h00000000, 3'b001};
      vecs[9]  = '{32'h80000001, 32'h80000000, 3'b001};
      vecs[10] = '{32'hff800000, 32'h7fc00000, 3'b100};
      vecs[11] = '{32'h7f812345, 32'h7fc00000, 3'b100};

      s_in_valid = 1'b0; s_in_a = '0; s_out_ready = 1'b0;
      h_in_valid = 1'b0; h_in_a = '0; h_out_ready = 1'b0;

      // reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready",  64'(s_in_ready),  64'd1);
      check("reset_out_valid", 64'(s_out_valid), 64'd0);
      check("reset_out_q",     64'(s_out_q),     64'd0);
      check("reset_out_flags", 64'(s_out_flags), 64'd0);
      check("reset_h_in_ready", 64'(h_in_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // table vectors
      for (int i = 0; i < 12; i++) begin
         run_s(vecs[i].a, q32, fl, lat);
         check($sformatf("vec%0d_q", i),     64'(q32), 64'(vecs[i].q));
         check($sformatf("vec%0d_flags", i), 64'(fl),  64'(vecs[i].f));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd27);
         check($sformatf("vec%0d_valid_drop", i), 64'(s_out_valid), 64'd0);
         check($sformatf("vec%0d_ready_back", i), 64'(s_in_ready),  64'd1);
      end

      // random single-precision operands
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: a32 = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            1: a32 = $urandom;
            2: begin
               case ($urandom_range(0, 3))
                  0: a32 = {1'b0, 8'd1,   23'($urandom)};
                  1: a32 = {1'b0, 8'd2,   23'($urandom)};
                  2: a32 = {1'b0, 8'd253, 23'($urandom)};
                  default: a32 = {1'b0, 8'd254, 23'($urandom)};
               endcase
            end
            default: a32 = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom) & 23'h7f0000};
         endcase
         exp_q.push_back(ref_sqrt(8, 23, 64'(a32)));
         run_s(a32, q32, fl, lat);
         e = exp_q.pop_front();
         check($sformatf("rand_s_q a=%h", a32),     64'(q32), 64'(e[31:0]));
         check($sformatf("rand_s_flags a=%h", a32), 64'(fl),  64'(e[34:32]));
         check($sformatf("rand_s_latency a=%h", a32), 64'(lat), 64'd27);
      end

      // output held under back-pressure; a pulse on in_valid while busy is ignored
      @(negedge clk);
      s_in_a = 32'h40000000;
      s_in_valid = 1'b1;
      check("hs_ready_before", 64'(s_in_ready), 64'd1);
      @(negedge clk);
      s_in_valid = 1'b0;
      lat = 0;
      repeat (5) begin
         @(negedge clk);
         lat++;
      end
      s_in_a = 32'h40800000;
      s_in_valid = 1'b1;
      check("hs_busy_not_ready", 64'(s_in_ready), 64'd0);
      @(negedge clk);
      lat++;
      s_in_valid = 1'b0;
      while (!s_out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("hs_latency", 64'(lat), 64'd27);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("hs_hold%0d_valid", i), 64'(s_out_valid), 64'd1);
         check($sformatf("hs_hold%0d_q", i),     64'(s_out_q),     64'h3fb504f3);
         check($sformatf("hs_hold%0d_flags", i), 64'(s_out_flags), 64'd2);
         check($sformatf("hs_hold%0d_in_ready", i), 64'(s_in_ready), 64'd0);
         @(negedge clk);
      end
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      check("hs_valid_after_take", 64'(s_out_valid), 64'd0);
      check("hs_ready_after_take", 64'(s_in_ready),  64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (s_out_valid) seen++;
      end
      check("hs_no_second_result", 64'(seen), 64'd0);

      // reset dropped in the middle of CALC
      @(negedge clk);
      s_in_a = 32'h40800000;
      s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_busy_before", 64'(s_in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready",  64'(s_in_ready),  64'd1);
      check("rst_mid_out_valid", 64'(s_out_valid), 64'd0);
      check("rst_mid_out_q",     64'(s_out_q),     64'd0);
      check("rst_mid_out_flags", 64'(s_out_flags), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_in_ready", 64'(s_in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (s_out_valid) seen++;
      end
      check("rst_no_result", 64'(seen), 64'd0);
      run_s(32'h3f800000, q32, fl, lat);
      check("rst_recover_q",       64'(q32), 64'h3f800000);
      check("rst_recover_latency", 64'(lat), 64'd27);

      // half precision
      run_h(16'h4400, q16, fl, lat);
      check("half_4_q",       64'(q16), 64'h4000);
      check("half_4_flags",   64'(fl),  64'd0);
      check("half_4_latency", 64'(lat), 64'd14);
      run_h(16'h3c00, q16, fl, lat);
      check("half_1_q",       64'(q16), 64'h3c00);
      check("half_1_latency", 64'(lat), 64'd14);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0) a16 = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
         else a16 = 16'($urandom);
         exp_q.push_back(ref_sqrt(5, 10, 64'(a16)));
         run_h(a16, q16, fl, lat);
         e = exp_q.pop_front();
         check($sformatf("rand_h_q a=%h", a16),     64'(q16), 64'(e[15:0]));
         check($sformatf("rand_h_flags a=%h", a16), 64'(fl),  64'(e[34:32]));
         check($sformatf("rand_h_latency a=%h", a16), 64'(lat), 64'd14);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
